dm_sized: RTL and testbench

- Parametrised, synchronous data memory for the P-series pipelined CPU; next generation of the word-only data memory.
- Supports byte, halfword and word loads and stores, with sign or zero extension on loads.
- Has a registered read port and reports registered address exceptions (AdEl for loads, AdEs for stores).
- A hardware clear sequencer zeroes the array after reset, because the asynchronous reset cannot clear the RAM array directly.
- Sits in the MEM stage; AdEl/AdEs feed the CP0 exception logic.

---
 rtl/dm_sized.sv | 164 ++++++++++++++++
 tb/tb_dm_sized.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dm_sized.sv
// rtl/dm_sized.sv - sized-access data memory with registered read, AdEl/AdEs and post-reset clear
// Optional store trace under `DM_TRACE_EN.
module dm_sized #(
  parameter int          DEPTH_WORDS = 3072,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] LIMIT_ADDR  = 32'h0000_2fff
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        We,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  input  logic [31:0] PC,
  output logic [31:0] RD,
  output logic        RValid,
  output logic        AdEl,
  output logic        AdEs,
  output logic        Busy
);
  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN  = LIMIT_ADDR - BASE_ADDR;

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [IDX_W-1:0] r_ptr;
  logic [31:0]      r_mem [DEPTH_WORDS];
  logic [31:0]      r_rd;
  logic             r_rvalid;
  logic             r_adel;
  logic             r_ades;

  logic             w_busy;
  logic             w_acc;
  logic             w_misalign;
  logic             w_range;
  logic             w_err;
  logic             w_mem_we;
  logic [32:0]      w_off;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_widx;
  logic [3:0]       w_lanes;
  logic [31:0]      w_old;
  logic [31:0]      w_wrep;
  logic [31:0]      w_bmask;
  logic [31:0]      w_merged;
  logic [31:0]      w_wword;
  logic [15:0]      w_lane;
  logic [31:0]      w_load;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_CLEAR;
      r_ptr   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_CLEAR) r_ptr <= r_ptr + IDX_W'(1);
    end
  end

  always_comb begin
    w_next = r_state;
    if (r_state == S_CLEAR && r_ptr == IDX_W'(DEPTH_WORDS - 1)) w_next = S_READY;
  end

  always_comb begin
    w_busy = (r_state == S_CLEAR);
  end

  // 33-bit offset: the borrow bit flags addresses below BASE_ADDR
  always_comb begin
    w_off   = {1'b0, A} - {1'b0, BASE_ADDR};
    w_range = w_off[32] | (w_off[31:0] > SPAN);
    case (Size)
      2'b01:   w_misalign = A[0];
      2'b10:   w_misalign = |A[1:0];
      2'b11:   w_misalign = 1'b1;
      default: w_misalign = 1'b0;
    endcase
    w_err = w_misalign | w_range;
    w_idx = w_off[IDX_W+1:2];
    w_acc = Req & ~w_busy;
    w_old = r_mem[w_idx];
  end

  always_comb begin
    case (Size)
      2'b00: begin
        w_lanes = 4'b0001 << A[1:0];
        w_wrep  = {4{WD[7:0]}};
      end
      2'b01: begin
        w_lanes = A[1] ? 4'b1100 : 4'b0011;
        w_wrep  = {2{WD[15:0]}};
      end
      default: begin
        w_lanes = 4'b1111;
        w_wrep  = WD;
      end
    endcase
    w_bmask  = {{8{w_lanes[3]}}, {8{w_lanes[2]}}, {8{w_lanes[1]}}, {8{w_lanes[0]}}};
    w_merged = (w_old & ~w_bmask) | (w_wrep & w_bmask);
    w_lane   = 16'(w_old >> {A[1:0], 3'b000});
    case (Size)
      2'b00:   w_load = Unsigned ? {24'h0, w_lane[7:0]} : {{24{w_lane[7]}}, w_lane[7:0]};
      2'b01:   w_load = Unsigned ? {16'h0, w_lane} : {{16{w_lane[15]}}, w_lane};
      default: w_load = w_old;
    endcase
  end

  // Reset gates the write so an access caught by reset never lands in the array
  always_comb begin
    w_mem_we = Reset & (w_busy | (w_acc & We & ~w_err));
    w_widx   = w_busy ? r_ptr : w_idx;
    w_wword  = w_busy ? 32'h0 : w_merged;
  end

  always_ff @(posedge Clk) begin
    if (w_mem_we) begin
      r_mem[w_widx] <= w_wword;
`ifdef DM_TRACE_EN
      if (!w_busy) $display("@%h: *%h <= %h", PC, {A[31:2], 2'b00}, w_merged);
`endif
    end
  end

`ifndef DM_TRACE_EN
  logic w_unused_pc;
  assign w_unused_pc = ^PC;
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_rd     <= '0;
      r_rvalid <= 1'b0;
      r_adel   <= 1'b0;
      r_ades   <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      r_adel   <= 1'b0;
      r_ades   <= 1'b0;
      if (w_acc) begin
        if (We) begin
          r_ades <= w_err;
        end else if (w_err) begin
          r_adel <= 1'b1;
        end else begin
          r_rd     <= w_load;
          r_rvalid <= 1'b1;
        end
      end
    end
  end

  assign RD     = r_rd;
  assign RValid = r_rvalid;
  assign AdEl   = r_adel;
  assign AdEs   = r_ades;
  assign Busy   = w_busy;
endmodule

// File: tb/tb_dm_sized.sv
// tb/tb_dm_sized.sv - self-checking bench for dm_sized against a byte-addressed reference model
module tb_dm_sized;
  localparam int          NBYTES = 12288;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam logic [31:0] LIMIT  = 32'h0000_2fff;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Req = 1'b0;
  logic        We = 1'b0;
  logic [1:0]  Size = 2'b00;
  logic        Unsigned = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] WD = '0;
  logic [31:0] PC = 32'h0040_0000;
  logic [31:0] RD;
  logic        RValid;
  logic        AdEl;
  logic        AdEs;
  logic        Busy;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [7:0]  mm [NBYTES];
  logic [31:0] exp_rd = '0;

  always #5 Clk = ~Clk;

  dm_sized dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .We(We), .Size(Size), .Unsigned(Unsigned),
    .A(A), .WD(WD), .PC(PC), .RD(RD), .RValid(RValid), .AdEl(AdEl), .AdEs(AdEs), .Busy(Busy)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish before 2ms");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_err(input logic [31:0] a, input logic [1:0] sz);
    int unsigned nb;
    if (sz == 2'b11) return 1'b1;
    nb = 1 << sz;
    return ((a % nb) != 0) || (longint'(a) < longint'(BASE)) || (longint'(a) > longint'(LIMIT));
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] sz, input bit uns);
    int unsigned o;
    longint v;
    o = a - BASE;
    case (sz)
      2'b00: begin
        v = mm[o];
        if (!uns && v >= 128) v = v - 256;
      end
      2'b01: begin
        v = mm[o] + 256 * mm[o+1];
        if (!uns && v >= 32768) v = v - 65536;
      end
      default: v = mm[o] + 256 * (mm[o+1] + 256 * (mm[o+2] + 256 * longint'(mm[o+3])));
    endcase
    return 32'(v);
  endfunction

  task automatic m_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int unsigned o;
    o = a - BASE;
    for (int i = 0; i < (1 << sz); i++) mm[o + i] = wd[8*i +: 8];
  endtask

  task automatic op(input string tag, input bit we, input logic [1:0] sz, input bit uns,
                    input logic [31:0] a, input logic [31:0] wd);
    bit err;
    logic [2:0] exp_p;
    @(negedge Clk);
    Req = 1'b1; We = we; Size = sz; Unsigned = uns; A = a; WD = wd; PC = PC + 32'd4;
    err = m_err(a, sz);
    @(posedge Clk);
    #1;
    Req = 1'b0;
    if (!err && we) m_store(a, sz, wd);
    if (!err && !we) exp_rd = m_load(a, sz, uns);
    exp_p = {!we && !err, !we && err, we && err};
    chk({tag, " rvalid/adel/ades"}, {29'b0, RValid, AdEl, AdEs}, {29'b0, exp_p});
    chk({tag, " rd"}, RD, exp_rd);
  endtask

  initial begin
    int  cnt;
    bit  pulse;
    logic [1:0]  rsz;
    logic [31:0] ra;
    for (int i = 0; i < NBYTES; i++) mm[i] = 8'h00;

    repeat (3) @(posedge Clk);
    #1;
    chk("reset busy", {31'b0, Busy}, 32'd1);
    chk("reset rd", RD, 32'h0);
    chk("reset pulses", {29'b0, RValid, AdEl, AdEs}, 32'h0);

    @(negedge Clk);
    Reset = 1'b1;
    repeat (100) @(posedge Clk);
    #1;
    chk("busy at clear cycle 100", {31'b0, Busy}, 32'd1);
    Reset = 1'b0;
    #1;
    chk("busy after mid-clear reset", {31'b0, Busy}, 32'd1);
    @(negedge Clk);
    Reset = 1'b1;

    cnt = 0;
    pulse = 1'b0;
    while (Busy && cnt < 5000) begin
      @(posedge Clk);
      #1;
      cnt++;
      pulse |= RValid | AdEl | AdEs;
      Req = (cnt >= 10 && cnt < 50);
      We = 1'b1; Size = 2'b10; A = 32'h0; WD = 32'hffff_ffff;
    end
    Req = 1'b0;
    chk("clear cycle count", cnt, 32'd3072);
    chk("no pulse while busy", {31'b0, pulse}, 32'd0);

    op("lw 0x2ffc after clear", 1'b0, 2'b10, 1'b0, 32'h2ffc, 32'h0);
    op("lw 0x0 after busy store", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);

    op("sw 0x10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344);
    op("sb 0x11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00aa);
    op("lw 0x10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("byte merge literal", RD, 32'h1122_aa44);
    op("lb 0x11", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    chk("lb literal", RD, 32'hffff_ffaa);
    op("lbu 0x11", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    chk("lbu literal", RD, 32'h0000_00aa);

    op("sh 0x22", 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_8001);
    op("lh 0x22", 1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
    chk("lh literal", RD, 32'hffff_8001);
    op("lhu 0x22", 1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
    chk("lhu literal", RD, 32'h0000_8001);
    op("lw 0x20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    chk("lw 0x20 literal", RD, 32'h8001_0000);

    op("lw 0x3000 range", 1'b0, 2'b10, 1'b0, 32'h3000, 32'h0);
    op("sh 0x13 misaligned", 1'b1, 2'b01, 1'b0, 32'h13, 32'hbeef);
    op("lw 0x10 after bad sh", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    op("size11 load 0x0", 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    op("lw 0x2fff misaligned", 1'b0, 2'b10, 1'b0, 32'h2fff, 32'h0);
    op("lbu 0x2fff edge", 1'b0, 2'b00, 1'b1, 32'h2fff, 32'h0);

    op("sw 0x40", 1'b1, 2'b10, 1'b0, 32'h40, 32'hdead_beef);
    op("lw 0x40 b2b", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    chk("b2b literal", RD, 32'hdead_beef);

    for (int k = 0; k < 400; k++) begin
      rsz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) ra = $urandom_range(32'h2ff0, 32'h3010);
      else ra = $urandom_range(0, 127);
      op("random", 1'($urandom_range(0, 1)), rsz, 1'($urandom_range(0, 1)), ra, $urandom);
    end

    op("sw 0x10 pre-reset", 1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678);
    op("lw 0x10 pre-reset", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(negedge Clk);
    Req = 1'b1; We = 1'b0; Size = 2'b10; A = 32'h10;
    #2;
    Reset = 1'b0;
    #1;
    chk("async reset rd", RD, 32'h0);
    chk("async reset pulses", {29'b0, RValid, AdEl, AdEs}, 32'h0);
    chk("async reset busy", {31'b0, Busy}, 32'd1);
    @(posedge Clk);
    #1;
    chk("no pulse after reset edge", {28'b0, RValid, AdEl, AdEs, Busy}, 32'd1);
    Req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
